pwm_duty_slew: RTL and testbench

Upstream stage of the 8-bit PWM generator. Accepts a target duty value over a load strobe. Drives the PWM generator's duty input, moving it toward the target by at most STEP counts per HOLD PWM periods (soft-start / slew limiting). Steps are paced by frame_tick, the PWM counter's carry-out, so the duty word changes only at period boundaries.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_duty_slew_if.sv | 25 ++
 rtl/pwm_duty_slew_rst_sync.sv | 23 ++
 rtl/pwm_duty_slew.sv | 127 ++++++++++++
 tb/tb_pwm_duty_slew.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Constants and types shared across the PWM chain (duty slew, generator, ...).
package pwm_pkg;

    localparam int unsigned        DUTY_W   = 8;
    localparam logic [DUTY_W-1:0]  RST_DUTY = 8'd128;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_duty_slew_if.sv
// Target/strobe/duty bundle between the duty controller and the slew stage.
interface pwm_duty_slew_if
    import pwm_pkg::*;
#(
    parameter int unsigned DW = DUTY_W
);

    logic [DW-1:0] tgt;
    logic          tgt_load;
    logic          frame_tick;
    logic [DW-1:0] Dout;
    logic          busy;
    logic          done;

    modport master (
        output tgt, tgt_load, frame_tick,
        input  Dout, busy, done
    );

    modport slave (
        input  tgt, tgt_load, frame_tick,
        output Dout, busy, done
    );

endinterface

// File: rtl/pwm_duty_slew_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases on the 2nd clock edge.
module rst_sync (
    input  logic clk,
    input  logic arst_in,
    output logic arst_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= 1'b0;
            sync_q <= meta_q;
        end
    end

    assign arst_out = sync_q;

endmodule

// File: rtl/pwm_duty_slew.sv
// Slew-limited duty stage: walks Dout toward the loaded target by at most STEP
// counts every HOLD frame ticks, so the PWM duty only changes at period edges.
module pwm_duty_slew
    import pwm_pkg::*;
#(
    parameter int unsigned   DW       = DUTY_W,
    parameter int unsigned   STEP     = 4,
    parameter int unsigned   HOLD     = 1,
    parameter logic [DW-1:0] RST_DUTY = DW'(pwm_pkg::RST_DUTY)
) (
    input  logic            CLK,
    input  logic            aRSTin,
    pwm_duty_slew_if.slave  sif
);

    logic arst;

    rst_sync u_rst_sync (
        .clk      (CLK),
        .arst_in  (aRSTin),
        .arst_out (arst)
    );

    state_e        state_q, state_d;
    logic [DW-1:0] dout_q,  dout_d;
    logic [DW-1:0] tgt_q,   tgt_d;
    logic [7:0]    hold_q,  hold_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic          up;
    logic [DW:0]   diff;

    // Distance is taken one bit wider so a step can never wrap past 0 or 2^DW-1.
    always_comb begin
        up   = (tgt_q > dout_q);
        diff = up ? ({1'b0, tgt_q} - {1'b0, dout_q})
                  : ({1'b0, dout_q} - {1'b0, tgt_q});
    end

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        tgt_d   = tgt_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (sif.tgt_load) begin
                    tgt_d = sif.tgt;
                    if (sif.tgt != dout_q) begin
                        hold_d  = '0;
                        state_d = RAMP;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            RAMP: begin
                if (sif.frame_tick) begin
                    if (hold_q != 8'(HOLD - 1)) begin
                        hold_d = hold_q + 8'd1;
                    end else begin
                        hold_d = '0;
                        if (diff <= (DW + 1)'(STEP)) begin
                            dout_d  = tgt_q;
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (up) begin
                            dout_d = dout_q + DW'(STEP);
                        end else begin
                            dout_d = dout_q - DW'(STEP);
                        end
                    end
                end

                // A coincident step has already used the old target; the new
                // target is judged against the post-step duty.
                if (sif.tgt_load) begin
                    tgt_d = sif.tgt;
                    if (sif.tgt == dout_d) begin
                        state_d = IDLE;
                        hold_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RAMP;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            dout_q  <= RST_DUTY;
            tgt_q   <= RST_DUTY;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            tgt_q   <= tgt_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sif.Dout = dout_q;
    assign sif.busy = busy_q;
    assign sif.done = done_q;

endmodule

// File: tb/tb_pwm_duty_slew.sv
// Directed bench for pwm_duty_slew: one HOLD=1 instance and one HOLD=3 instance.
module tb_pwm_duty_slew;

    logic CLK = 1'b0;
    logic rst;

    always #5 CLK = ~CLK;

    pwm_duty_slew_if #(.DW(8)) a_if ();
    pwm_duty_slew_if #(.DW(8)) b_if ();

    pwm_duty_slew #(.DW(8), .STEP(4), .HOLD(1), .RST_DUTY(8'd128)) u_a (
        .CLK    (CLK),
        .aRSTin (rst),
        .sif    (a_if)
    );

    pwm_duty_slew #(.DW(8), .STEP(4), .HOLD(3), .RST_DUTY(8'd128)) u_b (
        .CLK    (CLK),
        .aRSTin (rst),
        .sif    (b_if)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] tgt;
        logic       ld;
        logic       tk;
        logic [7:0] dout;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tv[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string nm, input logic [7:0] d, input logic b, input logic dn);
        chk({nm, ".Dout"}, a_if.Dout, d);
        chk({nm, ".busy"}, a_if.busy, b);
        chk({nm, ".done"}, a_if.done, dn);
    endtask

    // Drive both instances for one clock, then sample 1 time unit after the edge.
    task automatic cyc(input logic [7:0] t, input logic ld, input logic tk);
        a_if.tgt = t;  a_if.tgt_load = ld;  a_if.frame_tick = tk;
        b_if.tgt = t;  b_if.tgt_load = ld;  b_if.frame_tick = tk;
        @(posedge CLK);
        #1;
        a_if.tgt_load = 1'b0;  a_if.frame_tick = 1'b0;
        b_if.tgt_load = 1'b0;  b_if.frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_if.tgt = '0; a_if.tgt_load = 1'b0; a_if.frame_tick = 1'b0;
        b_if.tgt = '0; b_if.tgt_load = 1'b0; b_if.frame_tick = 1'b0;

        // Retarget / coincident-strobe table, applied from Dout=128 after reset
        tv[0]  = '{8'd200, 1'b1, 1'b0, 8'd128, 1'b1, 1'b0};
        tv[1]  = '{8'd0,   1'b0, 1'b1, 8'd132, 1'b1, 1'b0};
        tv[2]  = '{8'd0,   1'b0, 1'b1, 8'd136, 1'b1, 1'b0};
        tv[3]  = '{8'd130, 1'b1, 1'b0, 8'd136, 1'b1, 1'b0};
        tv[4]  = '{8'd0,   1'b0, 1'b1, 8'd132, 1'b1, 1'b0};
        tv[5]  = '{8'd0,   1'b0, 1'b1, 8'd130, 1'b0, 1'b1};
        tv[6]  = '{8'd0,   1'b0, 1'b0, 8'd130, 1'b0, 1'b0};
        tv[7]  = '{8'd0,   1'b0, 1'b1, 8'd130, 1'b0, 1'b0};
        tv[8]  = '{8'd150, 1'b1, 1'b0, 8'd130, 1'b1, 1'b0};
        tv[9]  = '{8'd0,   1'b0, 1'b1, 8'd134, 1'b1, 1'b0};
        tv[10] = '{8'd100, 1'b1, 1'b1, 8'd138, 1'b1, 1'b0};
        tv[11] = '{8'd0,   1'b0, 1'b1, 8'd134, 1'b1, 1'b0};
        tv[12] = '{8'd134, 1'b1, 1'b0, 8'd134, 1'b0, 1'b1};
        tv[13] = '{8'd0,   1'b0, 1'b0, 8'd134, 1'b0, 1'b0};
        tv[14] = '{8'd134, 1'b1, 1'b0, 8'd134, 1'b0, 1'b1};
        tv[15] = '{8'd0,   1'b0, 1'b0, 8'd134, 1'b0, 1'b0};
        tv[16] = '{8'd140, 1'b1, 1'b0, 8'd134, 1'b1, 1'b0};
        tv[17] = '{8'd0,   1'b0, 1'b1, 8'd138, 1'b1, 1'b0};
        tv[18] = '{8'd160, 1'b1, 1'b1, 8'd140, 1'b1, 1'b0};
        tv[19] = '{8'd0,   1'b0, 1'b1, 8'd144, 1'b1, 1'b0};

        // 1. Reset and release window
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_a("rst_hold", 8'd128, 1'b0, 1'b0);
            @(posedge CLK);
            #1;
        end
        rst = 1'b0;
        cyc(8'd200, 1'b1, 1'b0);
        chk_a("rel_edge1", 8'd128, 1'b0, 1'b0);
        cyc(8'd200, 1'b1, 1'b0);
        chk_a("rel_edge2", 8'd128, 1'b0, 1'b0);
        cyc(8'd0, 1'b0, 1'b1);
        chk_a("rel_after", 8'd128, 1'b0, 1'b0);

        // 2. Ramp up with ticks every 256 cycles
        cyc(8'd140, 1'b1, 1'b0);
        chk_a("up_load", 8'd128, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            repeat (255) cyc(8'd0, 1'b0, 1'b0);
            chk_a("up_pretick", 8'(128 + 4 * (k - 1)), 1'b1, 1'b0);
            cyc(8'd0, 1'b0, 1'b1);
            chk_a("up_tick", 8'(128 + 4 * k), (k != 3), (k == 3));
        end
        cyc(8'd0, 1'b0, 1'b0);
        chk_a("up_after", 8'd140, 1'b0, 1'b0);

        // 3. Ramp down to 0, then up to the top endpoint
        do_reset();
        cyc(8'd0, 1'b1, 1'b0);
        chk_a("dn_load", 8'd128, 1'b1, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            cyc(8'd0, 1'b0, 1'b1);
            chk_a("dn_tick", 8'(128 - 4 * k), (k != 32), (k == 32));
        end
        repeat (2) begin
            cyc(8'd0, 1'b0, 1'b1);
            chk_a("dn_idle_tick", 8'd0, 1'b0, 1'b0);
        end
        cyc(8'd250, 1'b1, 1'b0);
        for (int k = 1; k <= 62; k++) cyc(8'd0, 1'b0, 1'b1);
        chk_a("to250_pre", 8'd248, 1'b1, 1'b0);
        cyc(8'd0, 1'b0, 1'b1);
        chk_a("to250_end", 8'd250, 1'b0, 1'b1);
        cyc(8'd255, 1'b1, 1'b0);
        chk_a("top_load", 8'd250, 1'b1, 1'b0);
        cyc(8'd0, 1'b0, 1'b1);
        chk_a("top_t1", 8'd254, 1'b1, 1'b0);
        cyc(8'd0, 1'b0, 1'b1);
        chk_a("top_t2", 8'd255, 1'b0, 1'b1);
        cyc(8'd0, 1'b0, 1'b1);
        chk_a("top_idle", 8'd255, 1'b0, 1'b0);

        // 4. Retarget and coincident strobe table
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(tv[i].tgt, tv[i].ld, tv[i].tk);
            chk($sformatf("tv%0d.Dout", i), a_if.Dout, tv[i].dout);
            chk($sformatf("tv%0d.busy", i), a_if.busy, tv[i].busy);
            chk($sformatf("tv%0d.done", i), a_if.done, tv[i].done);
        end

        // 5. HOLD=3 instance
        do_reset();
        cyc(8'd136, 1'b1, 1'b0);
        chk("h3_load.busy", b_if.busy, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            cyc(8'd0, 1'b0, 1'b1);
            chk($sformatf("h3_tick%0d.Dout", k), b_if.Dout, (k < 3) ? 8'd128 : (k < 6) ? 8'd132 : 8'd136);
            chk($sformatf("h3_tick%0d.done", k), b_if.done, (k == 6));
        end
        for (int k = 0; k < 3; k++) begin
            cyc(8'd0, 1'b0, 1'b1);
            chk("h3_idle.Dout", b_if.Dout, 8'd136);
            chk("h3_idle.busy", b_if.busy, 1'b0);
        end

        // 6. Reset mid-ramp
        do_reset();
        cyc(8'd200, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) cyc(8'd0, 1'b0, 1'b1);
        chk_a("mid_pre", 8'd160, 1'b1, 1'b0);
        @(negedge CLK);
        rst = 1'b1;
        #1;
        chk_a("mid_async", 8'd128, 1'b0, 1'b0);
        cyc(8'd0, 1'b0, 1'b1);
        chk_a("mid_held", 8'd128, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) cyc(8'd0, 1'b0, 1'b0);
        chk_a("mid_rel", 8'd128, 1'b0, 1'b0);
        cyc(8'd0, 1'b0, 1'b1);
        chk_a("mid_idle_tick", 8'd128, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
